// File: rtl/mul_pkg.sv
// Shared types, widths and arithmetic helpers for the multiplier scheduler.
package mul_pkg;

  localparam int unsigned WORD  = 32;
  localparam int unsigned DWORD = 64;

  // Scheduler FSM encoding; plain constants keep older tools happy.
  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StIssue = 3'd1;
  localparam state_t StBusy  = 3'd2;
  localparam state_t StFixup = 3'd3;
  localparam state_t StDone  = 3'd4;

  // Magnitude of a 32-bit operand; 0x8000_0000 maps to itself and is read as unsigned.
  function automatic logic [WORD-1:0] mag32(input logic [WORD-1:0] v, input logic is_signed);
    mag32 = (is_signed && v[WORD-1]) ? (~v + WORD'(1)) : v;
  endfunction

  // 64-bit two's complement negate.
  function automatic logic [DWORD-1:0] neg64(input logic [DWORD-1:0] v);
    neg64 = ~v + DWORD'(1);
  endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module mul_rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  logic found;

  // Scan NREQ slots starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      logic [PtrW-1:0] sel;
      idx = 32'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PtrW'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/mul_sched.sv
// Shares one external 32x32 multiplier among NREQ requesters with round-robin arbitration,
// signed-to-magnitude conversion and sign restoration of the 64-bit product.
module mul_sched
  import mul_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      sgn,
  input  logic [NREQ*WORD-1:0] op_a,
  input  logic [NREQ*WORD-1:0] op_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DWORD-1:0]     product,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WORD-1:0]      mul_a,
  output logic [WORD-1:0]      mul_b,
  input  logic [DWORD-1:0]     mul_result,
  input  logic                 mul_ready
);

  localparam int unsigned PtrW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [WORD-1:0]   a_q, a_d;
  logic [WORD-1:0]   b_q, b_d;
  logic              neg_q, neg_d;
  logic [DWORD-1:0]  product_q, product_d;

  logic [NREQ-1:0]   arb_gnt;
  logic              arb_valid;
  logic [PtrW-1:0]   win_idx;
  logic [WORD-1:0]   win_a;
  logic [WORD-1:0]   win_b;
  logic              win_sgn;

  mul_rr_arb #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Route the winning requester's operands and sign mode.
  always_comb begin
    win_idx = '0;
    win_a   = '0;
    win_b   = '0;
    win_sgn = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_idx = PtrW'(i);
        win_a   = op_a[i*WORD +: WORD];
        win_b   = op_b[i*WORD +: WORD];
        win_sgn = sgn[i];
      end
    end
  end

  // FSM next state and datapath capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (arb_valid) begin
          owner_d = win_idx;
          a_d     = mag32(win_a, win_sgn);
          b_d     = mag32(win_b, win_sgn);
          neg_d   = win_sgn & (win_a[WORD-1] ^ win_b[WORD-1]);
          state_d = StIssue;
        end
      end
      // Ready is deliberately not looked at here: it may still be high from the last run.
      StIssue: state_d = StBusy;
      StBusy: begin
        if (mul_ready) state_d = StFixup;
      end
      StFixup: begin
        product_d = neg_q ? neg64(mul_result) : mul_result;
        state_d   = StDone;
      end
      StDone: begin
        ptr_d   = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + PtrW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Decoded outputs; grant is suppressed while reset is asserted.
  always_comb begin
    gnt  = (state_q == StIdle && rst_n) ? arb_gnt : '0;
    done = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      done[i] = (state_q == StDone) && (owner_q == PtrW'(i));
    end
  end

  assign busy      = (state_q != StIdle);
  assign mul_start = (state_q == StIssue);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural 34-cycle multiplier.
module tb_mul_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  sgn = '0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [63:0] product;
  logic        busy;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result = '0;
  logic        mul_ready = 1'b0;

  int ntests = 0;
  int nfail  = 0;

  mul_sched #(
    .NREQ (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .sgn        (sgn),
    .op_a       (op_a),
    .op_b       (op_b),
    .gnt        (gnt),
    .done       (done),
    .product    (product),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_ready  (mul_ready)
  );

  always #5 clk = ~clk;

  // Multiplier model: start clears ready; ready rises 34 cycles after the start cycle.
  // Result reads as garbage until ready so an early fixup is visible.
  int unsigned mcnt = 0;
  logic [63:0] mres_pend = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      mcnt       <= 33;
      mul_ready  <= 1'b0;
      mul_result <= 64'hDEAD_BEEF_DEAD_BEEF;
      mres_pend  <= {32'b0, mul_a} * {32'b0, mul_b};
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mul_ready  <= 1'b1;
        mul_result <= mres_pend;
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    ntests++;
    if (gnt !== 2'b00 || done !== 2'b00 || product !== 64'd0 || busy !== 1'b0 ||
        mul_start !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
      nfail++;
      $display("FAIL %s: gnt=%b done=%b product=%h busy=%b start=%b a=%h b=%h, all required 0",
               name, gnt, done, product, busy, mul_start, mul_a, mul_b);
    end
  endtask

  // One full transaction from requester idx; checks grant, issue, latency, product, hold.
  task automatic run_op(input int idx, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [63:0] ep,
                        input string name);
    logic [1:0] exp_g;
    int cyc;
    bit seen;
    bit busy_ok;
    exp_g = '0;
    exp_g[idx] = 1'b1;
    @(posedge clk); #1;
    req = '0;
    req[idx] = 1'b1;
    sgn[idx] = s;
    op_a[idx*32 +: 32] = a;
    op_b[idx*32 +: 32] = b;
    @(negedge clk);  // cycle 0
    ntests++;
    if (gnt !== exp_g) begin
      nfail++;
      $display("FAIL %s gnt: got %b expected %b", name, gnt, exp_g);
    end
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);  // cycle 1
    ntests++;
    if (mul_start !== 1'b1 || mul_a !== ea || mul_b !== eb) begin
      nfail++;
      $display("FAIL %s issue: start=%b a=%h b=%h expected start=1 a=%h b=%h",
               name, mul_start, mul_a, mul_b, ea, eb);
    end
    busy_ok = (busy === 1'b1);
    cyc = 1;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_ok = 0;
      if (done !== 2'b00) seen = 1;
    end
    ntests++;
    if (!seen || cyc != 37) begin
      nfail++;
      $display("FAIL %s latency: done seen=%0d at cycle %0d expected cycle 37", name, seen, cyc);
    end
    ntests++;
    if (done !== exp_g || product !== ep) begin
      nfail++;
      $display("FAIL %s result: done=%b product=%h expected done=%b product=%h",
               name, done, product, exp_g, ep);
    end
    ntests++;
    if (!busy_ok) begin
      nfail++;
      $display("FAIL %s busy: dropped during cycles 1..%0d, expected high", name, cyc);
    end
    @(negedge clk);  // cycle after done
    ntests++;
    if (busy !== 1'b0 || done !== 2'b00 || product !== ep) begin
      nfail++;
      $display("FAIL %s after: busy=%b done=%b product=%h expected busy=0 done=0 product=%h",
               name, busy, done, product, ep);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(0, 1'b0, 32'd7, 32'd6, 32'd7, 32'd6, 64'd42, "basic");
  endtask

  task automatic test_signed();
    run_op(1, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "signed");
  endtask

  // mul_ready is still high from the previous run while ISSUE is active.
  task automatic test_stale_ready();
    run_op(1, 1'b0, 32'h0000_1234, 32'h10, 32'h0000_1234, 32'h10, 64'h1_2340, "stale_ready");
  endtask

  task automatic test_corners();
    run_op(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000, "min_x_min");
    run_op(1, 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1,
           64'hFFFF_FFFF_8000_0000, "min_x_one");
    run_op(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, "umax_sq");
    run_op(0, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd5, 32'd0, 64'd0, "neg_zero");
  endtask

  // Both requesters held from reset: grants alternate starting at 0.
  task automatic test_contention();
    int got[$];
    int cyc;
    bit overlap;
    bit drained;
    apply_reset();
    @(posedge clk); #1;
    sgn  = 2'b00;
    op_a = {32'd3, 32'd2};
    op_b = {32'd5, 32'd4};
    req  = 2'b11;
    cyc = 0;
    overlap = 0;
    while (got.size() < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if ($countones(gnt) > 1) overlap = 1;
      if (gnt == 2'b01) got.push_back(0);
      else if (gnt == 2'b10) got.push_back(1);
    end
    @(posedge clk); #1;
    req = '0;
    drained = 0;
    for (int k = 0; k < 100 && !drained; k++) begin
      @(negedge clk);
      if (done !== 2'b00) drained = 1;
    end
    @(negedge clk);
    ntests++;
    if (got.size() != 4 || overlap || !drained) begin
      nfail++;
      $display("FAIL contention: grants=%0d overlap=%0d drained=%0d expected 4 0 1",
               got.size(), overlap, drained);
    end
    for (int k = 0; k < got.size(); k++) begin
      ntests++;
      if (got[k] != (k % 2)) begin
        nfail++;
        $display("FAIL contention order[%0d]: got %0d expected %0d", k, got[k], k % 2);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit stray;
    @(posedge clk); #1;
    sgn[0] = 1'b0;
    op_a[31:0] = 32'd9;
    op_b[31:0] = 32'd9;
    req = 2'b01;
    @(posedge clk); #1;  // cycle 1
    req = '0;
    repeat (9) @(posedge clk);
    #1;  // cycle 10
    rst_n = 1'b0;
    @(negedge clk);
    ntests++;
    if (busy !== 1'b1) begin
      nfail++;
      $display("FAIL reset_mid_op pre: busy=%b expected 1", busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);  // cycle 11
    check_idle_outputs("reset_mid_op");
    stray = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done !== 2'b00 || busy !== 1'b0) stray = 1;
    end
    ntests++;
    if (stray) begin
      nfail++;
      $display("FAIL reset_mid_op quiet: activity after reset, expected none");
    end
    run_op(0, 1'b0, 32'd2, 32'd3, 32'd2, 32'd3, 64'd6, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_stale_ready();
    test_corners();
    test_contention();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Round-robin scheduler sharing the single 32x32 shift-add multiplier among NREQ requesters (execution unit M/MR path, MH path, address arithmetic). Arbitrates, captures operands, converts signed requests to magnitudes, sequences the multiplier's start/ready handshake, and restores the sign of the 64-bit product. It sits between the requesting units and the multiplier instance.

## Interface
- NREQ, 2, number of requesters (2..8)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  NREQ  request per requester; held with operands until gnt
- sgn  in  NREQ  1 = signed (S/370 M semantics), 0 = unsigned
- op_a  in  NREQ*32  multiplicand, requester i at [32i+31:32i]
- op_b  in  NREQ*32  multiplier operand, same packing
- gnt  out  NREQ  one-cycle accept pulse, one-hot
- done  out  NREQ  one-cycle completion pulse, one-hot
- product  out  64  result; valid in the done cycle, held until next done
- busy  out  1  high in every state except IDLE
- mul_start  out  1  one-cycle start to multiplier
- mul_a, mul_b  out  32  operands to multiplier
- mul_result  in  64  multiplier product
- mul_ready  in  1  multiplier completion level

## Operation
- States: IDLE, ISSUE, BUSY, FIXUP, DONE.
- IDLE: if any req, pick first set bit starting at rr pointer (wrapping); pulse gnt[i]; capture owner, magnitudes |op_a|, |op_b| if sgn[i] else raw; neg = sgn[i] & (a[31]^b[31]); -> ISSUE. No req: stay.
- ISSUE: mul_start=1, mul_a/mul_b = captured magnitudes; -> BUSY.
- BUSY: wait for mul_ready=1; -> FIXUP. Never sampled in ISSUE (a stale high ready from the previous op is ignored; the multiplier clears ready on the start edge).
- FIXUP: product <= neg ? -mul_result (64-bit two's complement) : mul_result; -> DONE.
- DONE: done[owner]=1; rr pointer <= (owner+1) mod NREQ; -> IDLE.
- Width rules: magnitude of 0x8000_0000 is 0x8000_0000 unsigned (no overflow); all products fit 64 bits; neg with zero product yields 0.
- mul_a/mul_b held stable from ISSUE through FIXUP.
- req dropped before gnt: no grant, no error. Requests during non-IDLE states wait; arbitration only in IDLE, so a requester re-requesting in its DONE cycle is considered next cycle alongside others.
- Reset values: gnt=0, done=0, product=0, busy=0, mul_start=0, mul_a=mul_b=0, rr pointer=0, state IDLE.
- Reset mid-operation: everything returns to reset values next cycle; no done issued; the abandoned multiplier run is harmless because the next ISSUE restarts it.

## Timing
- gnt in cycle 0, mul_start in cycle 1.
- Team multiplier: mul_ready visible 34 cycles after start (cycle 35); product/done in cycle 37; next gnt earliest cycle 38.
- Generic: done = (cycle ready first seen in BUSY) + 2.
- Throughput: one multiply per (multiplier latency + 4) cycles.

## Structure
- Package mul_pkg: state enum, WORD=32, DWORD=64, magnitude and 64-bit negate functions.
- Sub-module mul_rr_arb: NREQ-wide round-robin priority picker (req, pointer -> one-hot grant, valid). Combinational; pointer register stays in mul_sched.
- Multiplier stays external; bench drives mul_ready/mul_result from a behavioural model with the 34-cycle latency.

## Test plan
- req0, sgn=0, a=7, b=6 -> gnt0 cycle 0, mul_start cycle 1 with 7/6, done0 cycle 37, product 42, busy high cycles 1..37.
- req1, sgn=1, a=0xFFFF_FFFD, b=5 -> mul_a=3, mul_b=5; product 0xFFFF_FFFF_FFFF_FFF1 on done1.
- Corners: signed 0x8000_0000 x 0x8000_0000 -> 0x4000_0000_0000_0000; signed 0x8000_0000 x 1 -> 0xFFFF_FFFF_8000_0000; unsigned 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001.
- Contention: req0 and req1 held continuously after reset -> grant order 0,1,0,1 over four ops; never two gnt bits together.
- Stale ready: model keeps mul_ready=1 through ISSUE -> no FIXUP; completion only after model drops and re-raises ready.
- Reset mid-op: rst_n low in BUSY cycle 10 -> next cycle all outputs 0, no done; subsequent req0 a=2, b=3 completes with product 6.
